// File: rtl/ddr_port_arbiter.sv
// Round-robin arbiter sharing one DDR read and one DDR write port.
// Each channel runs its own IDLE/ISSUE/RESP FSM with a watchdog.
module ddr_port_arb_chan #(
    parameter int N  = 4,
    parameter int AW = 32,
    parameter int TO = 4096,
    parameter int IW = 2
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic [N-1:0]    req_en_i,
    input  logic [N*AW-1:0] req_addr_i,
    input  logic            bus_done_i,
    input  logic            err_clear_i,
    output logic            en_o,
    output logic [AW-1:0]   addr_o,
    output logic [N-1:0]    done_o,
    output logic [IW-1:0]   grant_o,
    output logic            busy_o,
    output logic            issue_o,
    output logic            err_o
);
    localparam int CW = (TO > 0) ? $clog2(TO + 1) : 1;
    localparam logic [CW-1:0] TO_LIM = (TO > 0) ? CW'(TO - 1) : '0;
    localparam logic [CW-1:0] TO_MAX = (TO > 0) ? CW'(TO) : '0;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          pick_vld;
    logic [IW-1:0] pick_idx;
    logic [AW-1:0] pick_addr;
    logic          to_hit;

    // First requester at or above the pointer, wrapping at N
    always_comb begin : arb
        int s;
        s        = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 0; k < N; k++) begin
            s = int'(ptr_q) + k;
            if (s >= N) s = s - N;
            if (!pick_vld && req_en_i[IW'(s)]) begin
                pick_vld = 1'b1;
                pick_idx = IW'(s);
            end
        end
    end

    // Address slice of the selected requester
    always_comb begin
        pick_addr = '0;
        for (int k = 0; k < N; k++) begin
            if (pick_idx == IW'(k)) pick_addr = req_addr_i[k*AW +: AW];
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_vld) state_d = ISSUE;
            ISSUE:   if (bus_done_i) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant, address, pointer and watchdog next values
    always_comb begin
        grant_d = grant_q;
        addr_d  = addr_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        to_hit  = 1'b0;
        if (state_q == IDLE && pick_vld) begin
            grant_d = pick_idx;
            addr_d  = pick_addr;
            cnt_d   = '0;
        end
        if (state_q == ISSUE) begin
            if (cnt_q == TO_LIM) to_hit = (TO != 0);
            if (cnt_q != TO_MAX) cnt_d = cnt_q + 1'b1;
            if (bus_done_i) begin
                ptr_d = (grant_q == IW'(N - 1)) ? '0 : grant_q + 1'b1;
            end
        end
        // a new timeout beats a coincident clear
        err_d = err_q;
        if (err_clear_i) err_d = 1'b0;
        if (to_hit)      err_d = 1'b1;
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ptr_q   <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Outputs decoded from the registered state
    always_comb begin
        en_o    = (state_q == ISSUE);
        issue_o = (state_q == ISSUE);
        busy_o  = (state_q != IDLE);
        done_o  = '0;
        if (state_q == RESP) done_o[grant_q] = 1'b1;
    end

    assign addr_o  = addr_q;
    assign grant_o = grant_q;
    assign err_o   = err_q;
endmodule

module ddr_port_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int RD_BUF_LEN     = 1024,
    parameter int WR_BUF_LEN     = 1024,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int IW            = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ-1:0]            req_rd_en,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_rd_addr,
    output logic [NUM_REQ-1:0]            req_rd_done,
    output logic [RD_BUF_LEN-1:0]         req_rd_buffer,
    input  logic [NUM_REQ-1:0]            req_wr_en,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_wr_addr,
    input  logic [NUM_REQ*WR_BUF_LEN-1:0] req_wr_buffer,
    output logic [NUM_REQ-1:0]            req_wr_done,
    output logic                          uip2axi_rd_en,
    output logic                          uip2axi_wr_en,
    output logic [ADDR_WIDTH-1:0]         uip2axi_rd_addr,
    output logic [ADDR_WIDTH-1:0]         uip2axi_wr_addr,
    input  logic                          axi2uip_rd_done,
    input  logic                          axi2uip_wr_done,
    input  logic [RD_BUF_LEN-1:0]         rd_buffer,
    output logic [WR_BUF_LEN-1:0]         wr_buffer,
    output logic [IW-1:0]                 rd_grant_idx,
    output logic [IW-1:0]                 wr_grant_idx,
    output logic                          rd_busy,
    output logic                          wr_busy,
    output logic                          rd_timeout_err,
    output logic                          wr_timeout_err,
    input  logic                          err_clear
);
    logic rd_issue;
    logic wr_issue;

    ddr_port_arb_chan #(
        .N(NUM_REQ), .AW(ADDR_WIDTH), .TO(TIMEOUT_CYCLES), .IW(IW)
    ) u_rd (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .req_en_i    (req_rd_en),
        .req_addr_i  (req_rd_addr),
        .bus_done_i  (axi2uip_rd_done),
        .err_clear_i (err_clear),
        .en_o        (uip2axi_rd_en),
        .addr_o      (uip2axi_rd_addr),
        .done_o      (req_rd_done),
        .grant_o     (rd_grant_idx),
        .busy_o      (rd_busy),
        .issue_o     (rd_issue),
        .err_o       (rd_timeout_err)
    );

    ddr_port_arb_chan #(
        .N(NUM_REQ), .AW(ADDR_WIDTH), .TO(TIMEOUT_CYCLES), .IW(IW)
    ) u_wr (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .req_en_i    (req_wr_en),
        .req_addr_i  (req_wr_addr),
        .bus_done_i  (axi2uip_wr_done),
        .err_clear_i (err_clear),
        .en_o        (uip2axi_wr_en),
        .addr_o      (uip2axi_wr_addr),
        .done_o      (req_wr_done),
        .grant_o     (wr_grant_idx),
        .busy_o      (wr_busy),
        .issue_o     (wr_issue),
        .err_o       (wr_timeout_err)
    );

    // Read data is broadcast; each requester captures it on its own done
    assign req_rd_buffer = rd_buffer;

    // Write data follows the granted requester only while ISSUE is active
    always_comb begin
        wr_buffer = '0;
        if (wr_issue) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (wr_grant_idx == IW'(k)) begin
                    wr_buffer = req_wr_buffer[k*WR_BUF_LEN +: WR_BUF_LEN];
                end
            end
        end
    end

    // rd_issue mirrors uip2axi_rd_en and is kept for symmetry
    logic unused_rd_issue;
    assign unused_rd_issue = rd_issue;
endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed bench for ddr_port_arbiter: single read, round robin,
// concurrency, watchdog, async reset and spurious done.
module tb_ddr_port_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int BL = 128;

    logic            clk;
    logic            rstn;
    logic [N-1:0]    req_rd_en;
    logic [N*AW-1:0] req_rd_addr;
    logic [N-1:0]    req_rd_done;
    logic [BL-1:0]   req_rd_buffer;
    logic [N-1:0]    req_wr_en;
    logic [N*AW-1:0] req_wr_addr;
    logic [N*BL-1:0] req_wr_buffer;
    logic [N-1:0]    req_wr_done;
    logic            uip2axi_rd_en, uip2axi_wr_en;
    logic [AW-1:0]   uip2axi_rd_addr, uip2axi_wr_addr;
    logic            axi2uip_rd_done, axi2uip_wr_done;
    logic [BL-1:0]   rd_buffer;
    logic [BL-1:0]   wr_buffer;
    logic [1:0]      rd_grant_idx, wr_grant_idx;
    logic            rd_busy, wr_busy;
    logic            rd_timeout_err, wr_timeout_err;
    logic            err_clear;

    int checks = 0;
    int errors = 0;

    localparam logic [BL-1:0] PAT  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [BL-1:0] PAT2 = 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D;

    ddr_port_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .RD_BUF_LEN(BL),
        .WR_BUF_LEN(BL), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_rd_en(req_rd_en), .req_rd_addr(req_rd_addr),
        .req_rd_done(req_rd_done), .req_rd_buffer(req_rd_buffer),
        .req_wr_en(req_wr_en), .req_wr_addr(req_wr_addr),
        .req_wr_buffer(req_wr_buffer), .req_wr_done(req_wr_done),
        .uip2axi_rd_en(uip2axi_rd_en), .uip2axi_wr_en(uip2axi_wr_en),
        .uip2axi_rd_addr(uip2axi_rd_addr), .uip2axi_wr_addr(uip2axi_wr_addr),
        .axi2uip_rd_done(axi2uip_rd_done), .axi2uip_wr_done(axi2uip_wr_done),
        .rd_buffer(rd_buffer), .wr_buffer(wr_buffer),
        .rd_grant_idx(rd_grant_idx), .wr_grant_idx(wr_grant_idx),
        .rd_busy(rd_busy), .wr_busy(wr_busy),
        .rd_timeout_err(rd_timeout_err), .wr_timeout_err(wr_timeout_err),
        .err_clear(err_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [BL-1:0] obs,
                       input logic [BL-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BL-1:0] wpat(input int k);
        return {4{32'hC0DE_0000 + 32'(k)}};
    endfunction

    function automatic logic [AW-1:0] waddr(input int k);
        return 32'h2000_0000 + 32'(k * 256);
    endfunction

    // One write transaction for requester g, starting in IDLE
    task automatic wr_txn(input int g);
        step();
        chk("wr_en", 128'(uip2axi_wr_en), 128'(1));
        chk("wr_grant", 128'(wr_grant_idx), 128'(g));
        chk("wr_addr", 128'(uip2axi_wr_addr), 128'(waddr(g)));
        chk("wr_buf_a", wr_buffer, wpat(g));
        step();
        chk("wr_buf_b", wr_buffer, wpat(g));
        axi2uip_wr_done = 1'b1;
        step();
        axi2uip_wr_done = 1'b0;
        chk("wr_done", 128'(req_wr_done), 128'(4'b0001 << g));
        chk("wr_en_resp", 128'(uip2axi_wr_en), 128'(0));
        chk("wr_buf_resp", wr_buffer, 128'(0));
        req_wr_en[g] = 1'b0;
        step();
        chk("wr_done_end", 128'(req_wr_done), 128'(0));
        chk("wr_busy_idle", 128'(wr_busy), 128'(0));
    endtask

    initial begin
        rstn = 1'b0;
        req_rd_en = '0;
        req_wr_en = '0;
        axi2uip_rd_done = 1'b0;
        axi2uip_wr_done = 1'b0;
        rd_buffer = '0;
        err_clear = 1'b0;
        for (int k = 0; k < N; k++) begin
            req_rd_addr[k*AW +: AW] = 32'hA000_0000 + 32'(k);
            req_wr_addr[k*AW +: AW] = waddr(k);
            req_wr_buffer[k*BL +: BL] = wpat(k);
        end
        req_rd_addr[2*AW +: AW] = 32'h1000_0040;
        step();
        step();
        chk("rst_rd_en", 128'(uip2axi_rd_en), 128'(0));
        chk("rst_wr_en", 128'(uip2axi_wr_en), 128'(0));
        chk("rst_rd_addr", 128'(uip2axi_rd_addr), 128'(0));
        chk("rst_wr_buf", wr_buffer, 128'(0));
        chk("rst_grant", 128'({rd_grant_idx, wr_grant_idx}), 128'(0));
        chk("rst_busy", 128'({rd_busy, wr_busy}), 128'(0));
        chk("rst_done", 128'({req_rd_done, req_wr_done}), 128'(0));
        chk("rst_err", 128'({rd_timeout_err, wr_timeout_err}), 128'(0));
        rstn = 1'b1;
        step();

        // single read from requester 2, done 20 cycles after en
        req_rd_en = 4'b0100;
        chk("rd_en_pre", 128'(uip2axi_rd_en), 128'(0));
        step();
        chk("rd_en_1cyc", 128'(uip2axi_rd_en), 128'(1));
        chk("rd_addr", 128'(uip2axi_rd_addr), 128'(32'h1000_0040));
        chk("rd_grant", 128'(rd_grant_idx), 128'(2));
        chk("rd_busy", 128'(rd_busy), 128'(1));
        for (int i = 1; i < 20; i++) step();
        chk("rd_en_held", 128'(uip2axi_rd_en), 128'(1));
        axi2uip_rd_done = 1'b1;
        rd_buffer = PAT;
        step();
        axi2uip_rd_done = 1'b0;
        chk("rd_done", 128'(req_rd_done), 128'(4'b0100));
        chk("rd_data", req_rd_buffer, PAT);
        chk("rd_en_low1", 128'(uip2axi_rd_en), 128'(0));
        chk("rd_err_20cyc", 128'(rd_timeout_err), 128'(1));
        req_rd_en = 4'b0000;
        step();
        chk("rd_done_once", 128'(req_rd_done), 128'(0));
        chk("rd_en_low2", 128'(uip2axi_rd_en), 128'(0));
        chk("rd_busy_idle", 128'(rd_busy), 128'(0));
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk("rd_err_clr", 128'(rd_timeout_err), 128'(0));

        // spurious done while idle
        axi2uip_rd_done = 1'b1;
        step();
        axi2uip_rd_done = 1'b0;
        chk("spur_done", 128'(req_rd_done), 128'(0));
        chk("spur_busy", 128'(rd_busy), 128'(0));
        chk("spur_grant", 128'(rd_grant_idx), 128'(2));

        // round robin on the write channel
        req_wr_en = 4'b1111;
        wr_txn(0);
        wr_txn(1);
        wr_txn(2);
        wr_txn(3);
        req_wr_en = 4'b1001;
        wr_txn(0);
        wr_txn(3);

        // concurrent read (req 1) and write (req 3)
        req_rd_en = 4'b0010;
        req_wr_en = 4'b1000;
        step();
        chk("cc_en", 128'({uip2axi_rd_en, uip2axi_wr_en}), 128'(2'b11));
        chk("cc_rd_grant", 128'(rd_grant_idx), 128'(1));
        chk("cc_wr_grant", 128'(wr_grant_idx), 128'(3));
        chk("cc_rd_addr", 128'(uip2axi_rd_addr), 128'(32'hA000_0001));
        chk("cc_wr_buf", wr_buffer, wpat(3));
        step();
        axi2uip_rd_done = 1'b1;
        axi2uip_wr_done = 1'b1;
        rd_buffer = PAT2;
        step();
        axi2uip_rd_done = 1'b0;
        axi2uip_wr_done = 1'b0;
        chk("cc_rd_done", 128'(req_rd_done), 128'(4'b0010));
        chk("cc_wr_done", 128'(req_wr_done), 128'(4'b1000));
        chk("cc_rd_data", req_rd_buffer, PAT2);
        req_rd_en = 4'b0000;
        req_wr_en = 4'b0000;
        step();
        chk("cc_idle", 128'({rd_busy, wr_busy}), 128'(0));

        // watchdog: rd ptr is 2, so requester 0 is granted
        req_rd_en = 4'b0001;
        step();
        chk("wd_grant", 128'(rd_grant_idx), 128'(0));
        for (int i = 1; i < 16; i++) step();
        chk("wd_err_15", 128'(rd_timeout_err), 128'(0));
        step();
        chk("wd_err_16", 128'(rd_timeout_err), 128'(1));
        for (int i = 0; i < 4; i++) step();
        chk("wd_sticky", 128'(rd_timeout_err), 128'(1));
        chk("wd_en_wait", 128'(uip2axi_rd_en), 128'(1));
        axi2uip_rd_done = 1'b1;
        step();
        axi2uip_rd_done = 1'b0;
        chk("wd_late_done", 128'(req_rd_done), 128'(4'b0001));
        req_rd_en = 4'b0000;
        step();
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk("wd_cleared", 128'(rd_timeout_err), 128'(0));
        chk("wd_wr_err", 128'(wr_timeout_err), 128'(0));

        // async reset mid-ISSUE; rd ptr is 1 so requester 3 wins
        req_rd_en = 4'b1000;
        step();
        chk("rs_grant", 128'(rd_grant_idx), 128'(3));
        chk("rs_en_pre", 128'(uip2axi_rd_en), 128'(1));
        #2;
        rstn = 1'b0;
        req_rd_en = 4'b0000;
        #1;
        chk("rs_en", 128'(uip2axi_rd_en), 128'(0));
        chk("rs_busy", 128'(rd_busy), 128'(0));
        chk("rs_done", 128'(req_rd_done), 128'(0));
        chk("rs_grant0", 128'(rd_grant_idx), 128'(0));
        rstn = 1'b1;
        req_rd_en = 4'b0011;
        step();
        chk("rs_ptr0", 128'(rd_grant_idx), 128'(0));
        chk("rs_en_new", 128'(uip2axi_rd_en), 128'(1));
        axi2uip_rd_done = 1'b1;
        step();
        axi2uip_rd_done = 1'b0;
        chk("rs_done_new", 128'(req_rd_done), 128'(4'b0001));
        req_rd_en = 4'b0000;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ddr_port_arbiter.md
# ddr_port_arbiter

Round-robin arbiter that shares the single DDR read port and the single DDR write port among NUM_REQ on-chip requesters. Examples are layer engines, the graph/neighbour memory fetcher and the feature write-back unit. It sits between those requesters and the AXIS/AXI-MM bridge. Toward the bridge it drives the established level-enable / done-pulse handshake (uip2axi_*_en, axi2uip_*_done), so the bridge's rise-detect address-valid generation keeps working unchanged. The read and write channels are arbitrated independently and may be active concurrently.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 32, DDR byte address width
- RD_BUF_LEN, 1024, read burst buffer width (READ_BURST_LEN*C_S_AXIS_TDATA_WIDTH)
- WR_BUF_LEN, 1024, write burst buffer width (WRITE_BURST_LEN*C_M_AXIS_TDATA_WIDTH)
- TIMEOUT_CYCLES, 4096, watchdog limit per transaction; 0 disables the watchdog

Ports:
- clk  in  1  single clock
- rstn  in  1  asynchronous active-low reset
- req_rd_en  in  NUM_REQ  per-requester read request level
- req_rd_addr  in  NUM_REQ*ADDR_WIDTH  packed read addresses; requester i occupies slice i
- req_rd_done  out  NUM_REQ  one-cycle read-complete pulse to the granted requester
- req_rd_buffer  out  RD_BUF_LEN  rd_buffer broadcast to all requesters
- req_wr_en  in  NUM_REQ  per-requester write request level
- req_wr_addr  in  NUM_REQ*ADDR_WIDTH  packed write addresses
- req_wr_buffer  in  NUM_REQ*WR_BUF_LEN  packed write data
- req_wr_done  out  NUM_REQ  one-cycle write-complete pulse
- uip2axi_rd_en / uip2axi_wr_en  out  1  level enable to the bridge
- uip2axi_rd_addr / uip2axi_wr_addr  out  ADDR_WIDTH  registered address
- axi2uip_rd_done / axi2uip_wr_done  in  1  completion pulse from the bridge
- rd_buffer  in  RD_BUF_LEN  read data from the bridge
- wr_buffer  out  WR_BUF_LEN  write data, muxed from the granted requester
- rd_grant_idx / wr_grant_idx  out  clog2(NUM_REQ)  current or last granted requester
- rd_busy / wr_busy  out  1  channel is not in IDLE
- rd_timeout_err / wr_timeout_err  out  1  sticky watchdog flags
- err_clear  in  1  clears both sticky flags

## Operation
- Each channel runs an identical, independent FSM with states IDLE, ISSUE and RESP.
- IDLE:
  - If any req_*_en bit is high, select the first set bit searching upward (modulo NUM_REQ) from the round-robin pointer ptr.
  - Register grant_idx, register addr from that requester's slice, set uip2axi_*_en=1, go to ISSUE.
- ISSUE:
  - uip2axi_*_en is held high. Address and grant index are held stable. wr_buffer = req_wr_buffer slice[grant_idx].
  - When axi2uip_*_done=1: clear en, pulse req_*_done[grant_idx] for one cycle, set ptr = grant_idx+1 (wrapping NUM_REQ-1 to 0), go to RESP.
- RESP: req_*_done returns to 0; go to IDLE.
- Requester contract:
  - Hold req_*_en and its address/data stable from assertion until it sees its done pulse.
  - Deassert req_*_en at the clock edge that samples its done pulse.
  - Read data is valid on req_rd_buffer during the done cycle; the requester captures it there.
- Request changes while that requester is not granted are ignored until the next IDLE evaluation.
- Watchdog:
  - A per-channel counter resets on entry to ISSUE and increments each ISSUE cycle.
  - Reaching TIMEOUT_CYCLES sets *_timeout_err (sticky).
  - The FSM keeps waiting; it does not abort the transaction.
  - err_clear clears both flags. If err_clear coincides with a new timeout, the set wins.
- A done pulse arriving in IDLE or RESP is ignored.
- Read and write done pulses in the same cycle are handled independently, with no interaction.

## Timing
- Reset values:
  - All outputs 0: en, addr, wr_buffer (0 when not in ISSUE), done, grant_idx, busy, err.
  - ptr=0, state IDLE.
- Reset is asynchronous. Asserting rstn mid-transaction immediately drops en and aborts the transaction. The bridge is reset on the same rstn.
- Request-to-enable latency: req sampled high at edge t gives uip2axi_*_en high after edge t (one cycle).
- Done-to-requester latency: axi2uip_*_done sampled at edge d gives req_*_done high and en low after edge d.
- After each transaction en stays low for at least 2 cycles (RESP, IDLE). The bridge therefore always sees a fresh rising edge.
- Back-to-back throughput: one transaction per (bridge latency + 3) cycles per channel.
- busy is high in ISSUE and RESP.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,…,NUM_REQ-1. The maximum wait is NUM_REQ-1 transactions.

## Test plan
- Single read: req_rd_en[2]=1 with addr 0x1000_0040; bridge pulses done 20 cycles after en; rd_buffer=pattern. Required: en high 1 cycle after req; uip2axi_rd_addr=0x1000_0040; req_rd_done[2] pulses once; req_rd_buffer=pattern in that cycle; en low ≥2 cycles.
- Round robin: all four req_wr_en held high, each dropped after its done. Required: grants 0,1,2,3 in order. Then re-raise 0 and 3 with ptr=0 after the wrap: grant 0, then 3. wr_buffer matches the granted slice throughout each ISSUE.
- Concurrency: read from requester 1 and write from requester 3 raised in the same cycle, with done pulses in the same cycle. Required: both en assert together; both done pulses go to the correct indices; no cross-talk.
- Watchdog: TIMEOUT_CYCLES=16, bridge withholds done. Required: rd_timeout_err rises after 16 ISSUE cycles and stays high; a late done still completes the transaction; err_clear then clears the flag.
- Reset mid-operation: rstn low during ISSUE. Required: en, busy and done are 0 immediately (asynchronous); ptr=0. After release, a new request is granted normally.
- Spurious done: axi2uip_rd_done pulsed while IDLE. Required: no req_rd_done pulse and no state change.
